calc_input_sequencer: RTL and testbench
=======================================

Name: calc_input_sequencer

Overview:
- Upstream front end for the integer/float calculator top level.
- Debounces the enable pushbutton and walks the user through entering a mode, a bit-size and operands, all taken from 16 slide switches.
- Assembles 16/32/64-bit operands from 16-bit switch chunks and hands one complete request downstream with a valid/ready handshake.

Parameters:
- DEB_CYCLES, 16: consecutive stable-high cycles needed to accept a button press.
- SW_W, 16: switch bank width; operand chunk width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sw  in  SW_W  raw slide-switch value, sampled on an accepted press
- btn  in  1  raw enable pushbutton, asynchronous to clk
- operation  out  3  captured mode code
- in_size  out  2  captured size: 0 = 16-bit, 1 = 32-bit, 2 = 64-bit
- opa  out  64  assembled operand A
- opb  out  64  assembled operand B
- req_valid  out  1  request complete, outputs stable
- req_ready  in  1  downstream accepts the request
- stage  out  3  current FSM state code, for the prompt/LED display
- err  out  1  one-cycle pulse on an illegal mode or size entry

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - operation = 0, in_size = 0, opa = 0, opb = 0, req_valid = 0, err = 0.
  - FSM goes to S_MODE. Chunk counter and debouncer counter go to 0.
  - Reset mid-entry or mid-handshake discards all partial data.
- Input synchroniser and debouncer:
  - btn passes through a 2-flop synchroniser.
  - The counter increments while the synced level is 1 and saturates at DEB_CYCLES. It clears when the level is 0.
  - press is a single-cycle pulse on the cycle the counter reaches DEB_CYCLES.
  - Holding the button gives exactly one press. Release and re-press is required for the next one.
  - Presses in S_ISSUE are ignored.
- FSM states (stage code):
  - S_MODE(0): on press, capture operation = sw[2:0].
    - sw[2:0] in 110 or 111: pulse err and stay in S_MODE.
    - Otherwise go to S_SIZE.
  - S_SIZE(1): on press, capture in_size = sw[1:0].
    - sw[1:0] = 11: pulse err and stay in S_SIZE.
    - Otherwise clear opa, opb and the chunk counter, then go to S_OPA.
  - S_OPA(2): each press writes sw into opa[16k+15:16k], where k is the chunk counter. Chunks are loaded LSB first.
    - Chunks needed: N = 1, 2 or 4 for in_size 0, 1 or 2.
    - On the press that writes chunk N-1: if operation >= 100 (store or fetch, single operand), go to S_ISSUE. Otherwise reset the counter and go to S_OPB.
  - S_OPB(3): same chunk rules as S_OPA, writing into opb. After the last chunk, go to S_ISSUE.
  - S_ISSUE(4): req_valid = 1, and every output stays stable.
    - On a cycle with req_valid && req_ready: next cycle req_valid = 0 and the FSM returns to S_MODE.
    - operation, in_size, opa and opb hold their values until overwritten by the next entry.
- Width rule: bits above 16·N are 0 (zero-extension) unless the optional feature is enabled.
- Latency: from the raw btn rising edge to the press pulse is 2 + DEB_CYCLES cycles. The state update follows 1 cycle after the press.
- If req_ready is already high on entry to S_ISSUE, req_valid is high for exactly one cycle.

Optional Feature:
- Macro: CALC_SIGN_EXTEND_EN.
- Defined:
  - When the last chunk of an operand is written, the bits above 16·N are filled with bit 16·N-1 (two's-complement sign extension).
  - Applies to opa and opb for operation codes 001, 010 and 011. It is never applied to 000 (float), 100 or 101.
- Undefined: the upper bits stay 0.

Decomposition:
- Shared package calc_pkg holds:
  - Mode codes: OP_FLOAT = 000, OP_ARITH = 001, OP_SHIFT = 010, OP_LOGIC = 011, OP_STORE = 100, OP_FETCH = 101.
  - Size codes: SZ_16, SZ_32, SZ_64.
  - The FSM state enum, and a function chunks_for_size(size) returning 1, 2 or 4.
- One sub-module, btn_debounce (synchroniser plus counter plus single-pulse output), parameterised by DEB_CYCLES. It is reused for any future buttons.

Test Plan:
All scenarios use DEB_CYCLES = 4.
- Reset: rst held 2 cycles with btn = 1 -> all outputs 0, stage = 0, and no press is generated while rst is high.
- Glitch and hold: 2-cycle btn glitch -> no state change. Btn held 50 cycles -> exactly one press, and stage goes from 0 to 1.
- 32-bit arithmetic: mode 001, size 01, A chunks 0x5678 then 0x1234, B chunks 0xFFFF then 0x0000 -> opa = 0x0000_0000_1234_5678, opb = 0x0000_0000_0000_FFFF, then req_valid = 1.
- Store with backpressure: mode 100, size 00, A = 0x00AB -> goes straight to S_ISSUE. req_ready low 5 cycles then high -> req_valid stays high with outputs stable, drops 1 cycle after the handshake, and stage = 0.
- Illegal entries: mode sw = 111 -> err pulses 1 cycle and stage stays 0. Then size sw = 11 -> err pulses and stage stays 1. A legal retry then proceeds.
- Sign extension with CALC_SIGN_EXTEND_EN: mode 001, size 00, A = 0x8001 -> opa = 0xFFFF_FFFF_FFFF_8001. The same entry without the macro -> opa = 0x0000_0000_0000_8001.
- Reset mid-entry: rst after 1 of 4 chunks of a 64-bit A -> opa = 0, stage = 0.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared mode/size codes, sequencer states and operand helpers
package calc_pkg;

   localparam logic [2:0] OP_FLOAT = 3'b000;
   localparam logic [2:0] OP_ARITH = 3'b001;
   localparam logic [2:0] OP_SHIFT = 3'b010;
   localparam logic [2:0] OP_LOGIC = 3'b011;
   localparam logic [2:0] OP_STORE = 3'b100;
   localparam logic [2:0] OP_FETCH = 3'b101;

   localparam logic [1:0] SZ_16  = 2'd0;
   localparam logic [1:0] SZ_32  = 2'd1;
   localparam logic [1:0] SZ_64  = 2'd2;
   localparam logic [1:0] SZ_BAD = 2'd3;

   localparam int OPND_W = 64;

   typedef enum logic [2:0] {
      S_MODE  = 3'd0,
      S_SIZE  = 3'd1,
      S_OPA   = 3'd2,
      S_OPB   = 3'd3,
      S_ISSUE = 3'd4
   } state_t;

   function automatic logic [2:0] chunks_for_size(input logic [1:0] size);
      case (size)
         SZ_16:   return 3'd1;
         SZ_32:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic mode_is_illegal(input logic [2:0] op);
      return (op == 3'b110) || (op == 3'b111);
   endfunction

   function automatic logic mode_is_single(input logic [2:0] op);
      return (op == OP_STORE) || (op == OP_FETCH);
   endfunction

   // Only the integer modes carry two's-complement operands.
   function automatic logic mode_is_signed(input logic [2:0] op);
      return (op == OP_ARITH) || (op == OP_SHIFT) || (op == OP_LOGIC);
   endfunction

   function automatic logic [OPND_W-1:0] sign_extend(input logic [OPND_W-1:0] v,
                                                     input logic [1:0] size);
      case (size)
         SZ_16:   return {{48{v[15]}}, v[15:0]};
         SZ_32:   return {{32{v[31]}}, v[31:0]};
         default: return v;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchroniser, saturating stability counter, single press pulse
module btn_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         // Saturation at CNT_MAX keeps a held button from re-firing.
         if (!sync2)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
         press <= sync2 && (cnt == CNT_LAST);
      end
   end

endmodule

// File: rtl/calc_input_sequencer.sv
// rtl/calc_input_sequencer.sv - button-driven mode/size/operand entry; CALC_SIGN_EXTEND_EN enables operand sign extension
module calc_input_sequencer #(
   parameter int DEB_CYCLES = 16,
   parameter int SW_W       = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SW_W-1:0] sw,
   input  logic            btn,
   output logic [2:0]      operation,
   output logic [1:0]      in_size,
   output logic [63:0]     opa,
   output logic [63:0]     opb,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [2:0]      stage,
   output logic            err
);
   import calc_pkg::*;

   state_t      state;
   state_t      state_n;
   logic [2:0]  op_n;
   logic [1:0]  size_n;
   logic [63:0] opa_n;
   logic [63:0] opb_n;
   logic [1:0]  chunk;
   logic [1:0]  chunk_n;
   logic        err_n;
   logic        press;
   logic        last_chunk;

   btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_btn_debounce (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn),
      .press(press)
   );

   assign last_chunk = ({1'b0, chunk} == (chunks_for_size(in_size) - 3'd1));
   assign req_valid  = (state == S_ISSUE);
   assign stage      = state;

   always_comb begin
      state_n = state;
      op_n    = operation;
      size_n  = in_size;
      opa_n   = opa;
      opb_n   = opb;
      chunk_n = chunk;
      err_n   = 1'b0;

      case (state)
         S_MODE: begin
            if (press) begin
               op_n = sw[2:0];
               if (mode_is_illegal(sw[2:0]))
                  err_n = 1'b1;
               else
                  state_n = S_SIZE;
            end
         end
         S_SIZE: begin
            if (press) begin
               size_n = sw[1:0];
               if (sw[1:0] == SZ_BAD) begin
                  err_n = 1'b1;
               end else begin
                  opa_n   = '0;
                  opb_n   = '0;
                  chunk_n = '0;
                  state_n = S_OPA;
               end
            end
         end
         S_OPA: begin
            if (press) begin
               opa_n[chunk*SW_W +: SW_W] = sw;
               if (last_chunk) begin
`ifdef CALC_SIGN_EXTEND_EN
                  if (mode_is_signed(operation))
                     opa_n = sign_extend(opa_n, in_size);
`endif
                  chunk_n = '0;
                  state_n = mode_is_single(operation) ? S_ISSUE : S_OPB;
               end else begin
                  chunk_n = chunk + 2'd1;
               end
            end
         end
         S_OPB: begin
            if (press) begin
               opb_n[chunk*SW_W +: SW_W] = sw;
               if (last_chunk) begin
`ifdef CALC_SIGN_EXTEND_EN
                  if (mode_is_signed(operation))
                     opb_n = sign_extend(opb_n, in_size);
`endif
                  chunk_n = '0;
                  state_n = S_ISSUE;
               end else begin
                  chunk_n = chunk + 2'd1;
               end
            end
         end
         // Presses are deliberately ignored while the request is pending.
         S_ISSUE: begin
            if (req_ready)
               state_n = S_MODE;
         end
         default: state_n = S_MODE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_MODE;
         operation <= '0;
         in_size   <= '0;
         opa       <= '0;
         opb       <= '0;
         chunk     <= '0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         operation <= op_n;
         in_size   <= size_n;
         opa       <= opa_n;
         opb       <= opb_n;
         chunk     <= chunk_n;
         err       <= err_n;
      end
   end

endmodule

// File: tb/tb_calc_input_sequencer.sv
// tb/tb_calc_input_sequencer.sv - randomized self-checking bench against an entry-rule reference model
module tb_calc_input_sequencer;

   localparam int DEB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sw;
   logic        btn;
   logic        req_ready;
   logic [2:0]  operation;
   logic [1:0]  in_size;
   logic [63:0] opa;
   logic [63:0] opb;
   logic        req_valid;
   logic [2:0]  stage;
   logic        err;

   calc_input_sequencer #(.DEB_CYCLES(DEB), .SW_W(16)) dut (
      .clk(clk), .rst(rst), .sw(sw), .btn(btn),
      .operation(operation), .in_size(in_size), .opa(opa), .opb(opb),
      .req_valid(req_valid), .req_ready(req_ready), .stage(stage), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int err_seen = 0;
   int valid_seen = 0;

   always @(negedge clk) begin
      if (err === 1'b1) err_seen++;
      if (req_valid === 1'b1) valid_seen++;
   end

   // Reference model: what the user has entered so far
   int          m_stage;
   logic [2:0]  m_op;
   logic [1:0]  m_size;
   logic [63:0] m_a;
   logic [63:0] m_b;
   int          m_k;
   int          m_err = 0;

   task automatic model_reset();
      m_stage = 0; m_op = 0; m_size = 0; m_a = 0; m_b = 0; m_k = 0;
   endtask

   function automatic int n_chunks(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [63:0] extend(input logic [63:0] v, input int n, input logic [2:0] op);
      logic [63:0] hi;
      logic        sgn;
      hi  = ~((64'd1 << (16 * n)) - 64'd1);
      sgn = (op >= 3'd1 && op <= 3'd3) && v[16*n-1];
`ifdef CALC_SIGN_EXTEND_EN
      return sgn ? (v | hi) : v;
`else
      return sgn ? (v & ~hi) : (v & ~hi);
`endif
   endfunction

   task automatic model_press(input logic [15:0] v);
      case (m_stage)
         0: begin
            m_op = v[2:0];
            if (v[2:0] > 3'd5) m_err++; else m_stage = 1;
         end
         1: begin
            m_size = v[1:0];
            if (v[1:0] == 2'd3) m_err++;
            else begin m_a = 0; m_b = 0; m_k = 0; m_stage = 2; end
         end
         2: begin
            m_a = m_a | (64'(v) << (16 * m_k));
            m_k++;
            if (m_k == n_chunks(m_size)) begin
               m_a = extend(m_a, m_k, m_op);
               m_k = 0;
               m_stage = (m_op >= 3'd4) ? 4 : 3;
            end
         end
         3: begin
            m_b = m_b | (64'(v) << (16 * m_k));
            m_k++;
            if (m_k == n_chunks(m_size)) begin
               m_b = extend(m_b, m_k, m_op);
               m_k = 0;
               m_stage = 4;
            end
         end
         default: ;
      endcase
   endtask

   task automatic do_press(input logic [15:0] v, input int hold);
      sw = v;
      btn = 1'b1;
      repeat (hold) @(posedge clk);
      #1 btn = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      model_press(v);
   endtask

   task automatic apply_reset();
      rst = 1'b1; btn = 1'b0; req_ready = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic handshake(input int d);
      req_ready = 1'b0;
      for (int i = 0; i < d; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (req_valid !== 1'b1 || stage !== 3'd4 || opa !== m_a || opb !== m_b || operation !== m_op || in_size !== m_size) begin
            n_bad++;
            $display("FAIL hold_stable cyc=%0d: valid=%b stage=%0d opa=%h opb=%h op=%0d sz=%0d, need 1 4 %h %h %0d %0d",
                     i, req_valid, stage, opa, opb, operation, in_size, m_a, m_b, m_op, m_size);
         end
      end
      req_ready = 1'b1;
      @(posedge clk); #1 req_ready = 1'b0;
      m_stage = 0;
      n_cmp++;
      if (req_valid !== 1'b0 || stage !== 3'd0) begin
         n_bad++;
         $display("FAIL handshake_drop: valid=%b stage=%0d, need 0 0", req_valid, stage);
      end
      n_cmp++;
      if (opa !== m_a || opb !== m_b) begin
         n_bad++;
         $display("FAIL operands_held: opa=%h opb=%h, need %h %h", opa, opb, m_a, m_b);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; btn = 1'b1; sw = 16'hFFFF; req_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (operation !== 3'd0 || in_size !== 2'd0 || opa !== 64'd0 || opb !== 64'd0 ||
          req_valid !== 1'b0 || err !== 1'b0 || stage !== 3'd0) begin
         n_bad++;
         $display("FAIL reset_state: op=%0d sz=%0d opa=%h opb=%h valid=%b err=%b stage=%0d, need all 0",
                  operation, in_size, opa, opb, req_valid, err, stage);
      end
      btn = 1'b0; rst = 1'b0;
      model_reset();
      repeat (8) @(posedge clk);
      #1;
      n_cmp++;
      if (stage !== 3'd0 || err_seen !== 0) begin
         n_bad++;
         $display("FAIL reset_no_press: stage=%0d errs=%0d, need 0 0", stage, err_seen);
      end
   endtask

   task automatic test_glitch_hold();
      sw = 16'h0001;
      btn = 1'b1;
      repeat (2) @(posedge clk);
      #1 btn = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      n_cmp++;
      if (stage !== 3'd0) begin
         n_bad++;
         $display("FAIL glitch: stage=%0d, need 0", stage);
      end
      do_press(16'h0001, 50);
      n_cmp++;
      if (stage !== 3'd1 || operation !== 3'd1 || err_seen !== m_err) begin
         n_bad++;
         $display("FAIL hold_one_press: stage=%0d op=%0d errs=%0d, need 1 1 %0d", stage, operation, err_seen, m_err);
      end
      apply_reset();
   endtask

   task automatic test_arith32();
      do_press(16'h0001, DEB + 4);
      do_press(16'h0001, DEB + 4);
      do_press(16'h5678, DEB + 4);
      do_press(16'h1234, DEB + 4);
      do_press(16'hFFFF, DEB + 4);
      do_press(16'h0000, DEB + 4);
      n_cmp++;
      if (opa !== 64'h0000_0000_1234_5678 || opb !== 64'h0000_0000_0000_FFFF || req_valid !== 1'b1 || stage !== 3'd4) begin
         n_bad++;
         $display("FAIL arith32: opa=%h opb=%h valid=%b stage=%0d, need 12345678 0000ffff 1 4", opa, opb, req_valid, stage);
      end
      handshake(0);
   endtask

   task automatic test_store_backpressure();
      do_press(16'h0004, DEB + 4);
      do_press(16'h0000, DEB + 4);
      do_press(16'h00AB, DEB + 4);
      n_cmp++;
      if (stage !== 3'd4 || req_valid !== 1'b1 || opa !== 64'h00AB || operation !== 3'd4) begin
         n_bad++;
         $display("FAIL store_issue: stage=%0d valid=%b opa=%h op=%0d, need 4 1 ab 4", stage, req_valid, opa, operation);
      end
      do_press(16'h1234, DEB + 4);
      n_cmp++;
      if (stage !== 3'd4 || opa !== 64'h00AB) begin
         n_bad++;
         $display("FAIL issue_ignores_press: stage=%0d opa=%h, need 4 ab", stage, opa);
      end
      handshake(5);
   endtask

   task automatic test_illegal();
      int e0;
      e0 = err_seen;
      do_press(16'h0007, DEB + 4);
      n_cmp++;
      if (err_seen !== e0 + 1 || stage !== 3'd0) begin
         n_bad++;
         $display("FAIL bad_mode: err_cycles=%0d stage=%0d, need 1 0", err_seen - e0, stage);
      end
      do_press(16'h0002, DEB + 4);
      do_press(16'h0003, DEB + 4);
      n_cmp++;
      if (err_seen !== e0 + 2 || stage !== 3'd1) begin
         n_bad++;
         $display("FAIL bad_size: err_cycles=%0d stage=%0d, need 2 1", err_seen - e0, stage);
      end
      do_press(16'h0000, DEB + 4);
      n_cmp++;
      if (stage !== 3'd2) begin
         n_bad++;
         $display("FAIL legal_retry: stage=%0d, need 2", stage);
      end
      do_press(16'hC3A5, DEB + 4);
      do_press(16'h0F0F, DEB + 4);
      n_cmp++;
      if (opa !== m_a || opb !== m_b || stage !== 3'd4) begin
         n_bad++;
         $display("FAIL retry_operands: opa=%h opb=%h stage=%0d, need %h %h 4", opa, opb, stage, m_a, m_b);
      end
      handshake(1);
   endtask

   task automatic test_sign_ext();
      logic [63:0] want;
`ifdef CALC_SIGN_EXTEND_EN
      want = 64'hFFFF_FFFF_FFFF_8001;
`else
      want = 64'h0000_0000_0000_8001;
`endif
      do_press(16'h0001, DEB + 4);
      do_press(16'h0000, DEB + 4);
      do_press(16'h8001, DEB + 4);
      do_press(16'h0001, DEB + 4);
      n_cmp++;
      if (opa !== want || opb !== 64'h1) begin
         n_bad++;
         $display("FAIL sign_ext: opa=%h opb=%h, need %h 1", opa, opb, want);
      end
      handshake(0);
   endtask

   task automatic test_back_to_back();
      int v0;
      v0 = valid_seen;
      do_press(16'h0005, DEB + 4);
      do_press(16'h0001, DEB + 4);
      do_press(16'hAAAA, DEB + 4);
      req_ready = 1'b1;
      do_press(16'h9555, DEB + 4);
      req_ready = 1'b0;
      m_stage = 0;
      n_cmp++;
      if (valid_seen - v0 !== 1 || stage !== 3'd0 || opa !== m_a) begin
         n_bad++;
         $display("FAIL ready_on_entry: valid_cycles=%0d stage=%0d opa=%h, need 1 0 %h", valid_seen - v0, stage, opa, m_a);
      end
   endtask

   task automatic test_random();
      logic [15:0] r;
      for (int it = 0; it < 8; it++) begin
         r = 16'($urandom);
         r[2:0] = 3'($urandom_range(0, 5));
         do_press(r, DEB + 4);
         r = 16'($urandom);
         r[1:0] = 2'($urandom_range(0, 2));
         do_press(r, DEB + 4);
         for (int p = 0; p < 10 && (m_stage == 2 || m_stage == 3); p++)
            do_press(16'($urandom), DEB + 1 + int'($urandom_range(0, 4)));
         n_cmp++;
         if (stage !== 3'(m_stage) || operation !== m_op || in_size !== m_size ||
             opa !== m_a || opb !== m_b || req_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL random_entry it=%0d: stage=%0d op=%0d sz=%0d opa=%h opb=%h valid=%b, need %0d %0d %0d %h %h 1",
                     it, stage, operation, in_size, opa, opb, req_valid, m_stage, m_op, m_size, m_a, m_b);
         end
         handshake(int'($urandom_range(0, 3)));
      end
      n_cmp++;
      if (err_seen !== m_err) begin
         n_bad++;
         $display("FAIL err_total: %0d, need %0d", err_seen, m_err);
      end
   endtask

   task automatic test_reset_mid();
      do_press(16'h0003, DEB + 4);
      do_press(16'h0002, DEB + 4);
      do_press(16'hBEEF, DEB + 4);
      n_cmp++;
      if (stage !== 3'd2 || opa !== 64'hBEEF) begin
         n_bad++;
         $display("FAIL mid_entry: stage=%0d opa=%h, need 2 beef", stage, opa);
      end
      apply_reset();
      n_cmp++;
      if (opa !== 64'd0 || stage !== 3'd0 || operation !== 3'd0 || in_size !== 2'd0) begin
         n_bad++;
         $display("FAIL reset_mid: opa=%h stage=%0d op=%0d sz=%0d, need 0 0 0 0", opa, stage, operation, in_size);
      end
   endtask

   initial begin
      test_reset();
      test_glitch_hold();
      test_arith32();
      test_store_backpressure();
      test_illegal();
      test_sign_ext();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
